ps2_tx: RTL
===========

Name: ps2_tx

Overview:
- Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 8'hED (set LEDs) or 8'hFF (reset).
- It is the counterpart of the ps2_rx receiver and shares the open-drain ps2c/ps2d lines with it.
- The top level gates the receiver with rx_en = tx_idle, so the two blocks never drive or sample the lines at the same time.

Parameters:
- INHIBIT_CYCLES, 12000: clk cycles the host holds ps2c low for request-to-send (120 µs at 100 MHz).
- TIMEOUT_CYCLES, 2000000: maximum clk cycles between device falling edges before the transfer aborts (20 ms).
- FILTER_LEN, 8: number of consecutive identical ps2c samples needed to change the filtered clock.

Ports:
- clk, input, 1: 100 MHz system clock.
- reset, input, 1: asynchronous, active-low reset.
- wr_ps2, input, 1: one-cycle start strobe; honoured only while tx_idle=1.
- tx_data, input, 8: byte to send; latched on an accepted wr_ps2.
- ps2c, inout, 1: PS/2 clock, open-drain (driven 0 or released to Z).
- ps2d, inout, 1: PS/2 data, open-drain (driven 0 or released to Z).
- tx_idle, output, 1: 1 when no transfer is in progress.
- tx_done_tick, output, 1: one-cycle pulse when a transfer completes, with or without ACK.
- ack_err, output, 1: set when the device did not ACK; holds until the next accepted wr_ps2.
- timeout_err, output, 1: one-cycle pulse when a transfer aborts on timeout.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, tx_idle=1, tx_done_tick=0, ack_err=0, timeout_err=0.
  - Both line enables are cleared, so the lines are released in the same cycle reset asserts.
  - Reset mid-transfer therefore drops the transfer without any error pulse.
- Line drive: ps2c = c_oe ? 0 : Z and ps2d = d_oe ? 0 : Z, with c_oe and d_oe as registered flops. A 1 is sent by releasing the line.
- Input conditioning:
  - ps2d passes through a 2-flop synchronizer.
  - ps2c is sampled into a FILTER_LEN shift register; the filtered clock goes 1 when all samples are 1, goes 0 when all are 0, and otherwise holds.
  - fall = filtered clock was 1 last cycle and is 0 now.
- Parity: odd parity, p = ~^tx_data, computed at latch time. A 9-bit shift register holds {p, tx_data}.
- FSM states:
  - IDLE: tx_idle=1. wr_ps2 latches data, clears ack_err and goes to RTS. wr_ps2 in any other state is ignored.
  - RTS: c_oe=1 for INHIBIT_CYCLES. On the final count set d_oe=1 (start bit) and c_oe=0, then go to START.
  - START: hold d_oe=1. On fall, drive bit0 (d_oe = ~shreg[0]), set n=0, go to DATA.
  - DATA: on each fall, shift and drive the next bit; n counts 0..8 (d0..d7, then parity). On the fall that follows the parity bit, set d_oe=0 (stop bit released) and go to STOP.
  - STOP: on fall, sample synchronized ps2d; 0 means ACK, 1 sets ack_err=1. Go to WAIT_REL.
  - WAIT_REL: when filtered ps2c=1 and ps2d=1, pulse tx_done_tick and go to IDLE.
- Device falling-edge sequence: fall 1 → d0 … fall 8 → d7, fall 9 → parity, fall 10 → release, fall 11 → ACK sample.
- Watchdog:
  - Counts in START, DATA, STOP and WAIT_REL, and reloads on every fall.
  - On reaching TIMEOUT_CYCLES: release both lines, pulse timeout_err, go to IDLE.
  - tx_done_tick is not pulsed on timeout, and ack_err keeps its value.
- Simultaneous events: a fall on the same cycle the watchdog expires counts as progress; no timeout is taken.
- Counter widths: each counter is sized with $clog2 of its parameter. The watchdog is at least 21 bits.
- Latency: the line protocol is the only latency. tx_done_tick fires 1 cycle after the lines return high in WAIT_REL.

Decomposition:
- ps2_pkg holds:
  - the tx state enum (IDLE, RTS, START, DATA, STOP, WAIT_REL);
  - the default INHIBIT_CYCLES, TIMEOUT_CYCLES and FILTER_LEN values;
  - a function for the odd-parity bit.
- Sub-module ps2_clk_filter (synchronizer, FILTER_LEN filter, fall output). ps2_rx reuses it.

Test Plan:
1. wr_ps2 with tx_data=8'hED → ps2c low 12000 cycles, then ps2d low. The device BFM samples on rising edges: 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1. BFM ACKs → one tx_done_tick, ack_err=0.
2. Parity sweep: 8'h00 → p=1; 8'hFF → p=1; 8'h01 → p=0; 8'h03 → p=1. All are checked by the BFM.
3. BFM leaves ps2d high at the ACK clock → tx_done_tick with ack_err=1. The next accepted wr_ps2 clears ack_err.
4. BFM never clocks after RTS → timeout_err after 2000000 cycles, both lines Z, tx_idle=1, no tx_done_tick.
5. wr_ps2 with 8'h55 during DATA of an 8'hED transfer → ignored; the BFM receives 8'hED only. reset=0 mid-DATA → lines Z and tx_idle=1 immediately.
6. 5-cycle low glitch on ps2c during DATA → no bit advance. A 9-cycle low pulse → advances exactly one bit.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side blocks.
// Contents:
//   tx_state_e        - host-to-device transmitter states
//   *_DEF             - default timing parameters for a 100 MHz clk
//   odd_parity()      - parity bit that makes {p, data} carry an odd number of ones
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRts,
    StStart,
    StData,
    StStop,
    StWaitRel
  } tx_state_e;

  localparam int unsigned INHIBIT_CYCLES_DEF = 12000;    // 120 us request-to-send
  localparam int unsigned TIMEOUT_CYCLES_DEF = 2000000;  // 20 ms between device edges
  localparam int unsigned FILTER_LEN_DEF     = 8;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 line conditioner, shared by ps2_tx and ps2_rx.
// Ports:
//   clk, reset  - system clock, asynchronous active-low reset
//   ps2c_in     - raw PS/2 clock line
//   ps2d_in     - raw PS/2 data line
//   clk_f       - filtered PS/2 clock
//   fall        - one-cycle pulse on a filtered clock falling edge
//   d_sync      - 2-flop synchronized PS/2 data
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_in,
  input  logic ps2d_in,
  output logic clk_f,
  output logic fall,
  output logic d_sync
);

  logic [FILTER_LEN-1:0] filt_q;
  logic                  clk_f_q, clk_f_d;
  logic [1:0]            d_sync_q;

  // Lines idle high, so reset to the released state to avoid a spurious fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q   <= '1;
      clk_f_q  <= 1'b1;
      d_sync_q <= 2'b11;
    end else begin
      filt_q   <= {filt_q[FILTER_LEN-2:0], ps2c_in};
      clk_f_q  <= clk_f_d;
      d_sync_q <= {d_sync_q[0], ps2d_in};
    end
  end

  // Change only on a unanimous window; anything mixed holds the old value.
  always_comb begin
    clk_f_d = clk_f_q;
    if (&filt_q) begin
      clk_f_d = 1'b1;
    end else if (~|filt_q) begin
      clk_f_d = 1'b0;
    end
  end

  assign clk_f  = clk_f_q;
  assign fall   = clk_f_q & ~clk_f_d;
  assign d_sync = d_sync_q[1];

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte to the keyboard.
// Ports:
//   clk, reset    - 100 MHz clock, asynchronous active-low reset
//   wr_ps2        - start strobe, accepted only while tx_idle
//   tx_data       - byte to send, latched on an accepted wr_ps2
//   ps2c, ps2d    - open-drain PS/2 clock and data (driven 0 or released)
//   tx_idle       - no transfer in progress
//   tx_done_tick  - one-cycle pulse when a transfer completes (ACK or not)
//   ack_err       - device did not ACK; held until the next accepted wr_ps2
//   timeout_err   - one-cycle pulse when the watchdog aborts a transfer
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned FILTER_LEN     = FILTER_LEN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] tx_data,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int unsigned InhW = ($clog2(INHIBIT_CYCLES) > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned WdW  = ($clog2(TIMEOUT_CYCLES) > 21) ? $clog2(TIMEOUT_CYCLES) : 21;
  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT_CYCLES - 1);

  tx_state_e       state_q, state_d;
  logic [InhW-1:0] inh_q, inh_d;
  logic [WdW-1:0]  wd_q, wd_d;
  logic [3:0]      n_q, n_d;
  logic [8:0]      shreg_q, shreg_d;
  logic            c_oe_q, c_oe_d;
  logic            d_oe_q, d_oe_d;
  logic            ack_err_q, ack_err_d;
  logic            done_q, done_d;
  logic            tout_q, tout_d;

  logic clk_f, fall, d_sync;
  logic wd_active;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk    (clk),
    .reset  (reset),
    .ps2c_in(ps2c),
    .ps2d_in(ps2d),
    .clk_f  (clk_f),
    .fall   (fall),
    .d_sync (d_sync)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      inh_q     <= '0;
      wd_q      <= '0;
      n_q       <= '0;
      shreg_q   <= '0;
      c_oe_q    <= 1'b0;
      d_oe_q    <= 1'b0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_q     <= inh_d;
      wd_q      <= wd_d;
      n_q       <= n_d;
      shreg_q   <= shreg_d;
      c_oe_q    <= c_oe_d;
      d_oe_q    <= d_oe_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
      tout_q    <= tout_d;
    end
  end

  assign wd_active = (state_q == StStart) || (state_q == StData) ||
                     (state_q == StStop)  || (state_q == StWaitRel);

  always_comb begin
    state_d   = state_q;
    inh_d     = inh_q;
    wd_d      = '0;
    n_d       = n_q;
    shreg_d   = shreg_q;
    c_oe_d    = c_oe_q;
    d_oe_d    = d_oe_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    tout_d    = 1'b0;

    if (wd_active && !fall) begin
      wd_d = wd_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (wr_ps2) begin
          shreg_d   = {odd_parity(tx_data), tx_data};
          ack_err_d = 1'b0;
          inh_d     = '0;
          c_oe_d    = 1'b1;
          state_d   = StRts;
        end
      end
      StRts: begin
        if (inh_q == InhLast) begin
          c_oe_d  = 1'b0;
          d_oe_d  = 1'b1;  // start bit
          state_d = StStart;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      StStart: begin
        if (fall) begin
          d_oe_d  = ~shreg_q[0];
          n_d     = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (fall) begin
          if (n_q == 4'd8) begin
            d_oe_d  = 1'b0;  // stop bit: release data
            state_d = StStop;
          end else begin
            shreg_d = {1'b0, shreg_q[8:1]};
            d_oe_d  = ~shreg_q[1];
            n_d     = n_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (fall) begin
          ack_err_d = d_sync;
          state_d   = StWaitRel;
        end
      end
      StWaitRel: begin
        if (clk_f && d_sync) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A fall in the expiry cycle counts as progress, so it suppresses the abort.
    if (wd_active && !fall && (wd_q == WdLast)) begin
      c_oe_d  = 1'b0;
      d_oe_d  = 1'b0;
      done_d  = 1'b0;
      tout_d  = 1'b1;
      wd_d    = '0;
      state_d = StIdle;
    end
  end

  assign ps2c = c_oe_q ? 1'b0 : 1'bz;
  assign ps2d = d_oe_q ? 1'b0 : 1'bz;

  assign tx_idle      = (state_q == StIdle);
  assign tx_done_tick = done_q;
  assign ack_err      = ack_err_q;
  assign timeout_err  = tout_q;

endmodule
